// File: rtl/thor2022_bpred_update_queue.sv
// In-order branch tracking queue between fetch-time prediction and execute-time resolution.
// Optional statistics counters are enabled by defining THOR2022_BUQ_STATS_EN.
module thor2022_bpred_update_queue #(
    parameter int ABITS = 32,
    parameter int HISTW = 3,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [ABITS-1:0]           push_ip,
    input  logic                       push_taken,
    input  logic [HISTW-1:0]           push_hist,
    input  logic                       res_valid,
    input  logic                       res_takb,
    output logic                       upd_valid,
    output logic [ABITS-1:0]           upd_ip,
    output logic                       upd_takb,
    output logic [HISTW-1:0]           upd_hist,
    output logic                       mispredict,
    output logic [HISTW-1:0]           hist_restore,
    output logic [$clog2(DEPTH):0]     count,
`ifdef THOR2022_BUQ_STATS_EN
    output logic [31:0]                stat_branches,
    output logic [31:0]                stat_mispredicts,
`endif
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] ONE = 1;

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [ABITS-1:0] ip_mem [DEPTH];
    logic             tk_mem [DEPTH];
    logic [HISTW-1:0] hs_mem [DEPTH];

    logic full, empty, pop, mis, push_acc;
    logic [AW-1:0] head_idx;

    assign head_idx   = head_q[AW-1:0];
    assign empty      = (head_q == tail_q);
    assign full       = (head_q[PW-1] != tail_q[PW-1]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
    assign push_ready = !full;
    assign count      = tail_q - head_q;
    assign pop        = res_valid && !empty;
    assign mis        = pop && (res_takb != tk_mem[head_idx]);
    assign push_acc   = push_valid && !full;

    // Flush overrides everything for pointers; a mispredict squashes all younger entries.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = tail_q;
        end else if (mis) begin
            head_d = head_q + ONE;
            tail_d = head_q + ONE;
        end else begin
            if (pop)      head_d = head_q + ONE;
            if (push_acc) tail_d = tail_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc && !flush && !mis) begin
            ip_mem[tail_q[AW-1:0]] <= push_ip;
            tk_mem[tail_q[AW-1:0]] <= push_taken;
            hs_mem[tail_q[AW-1:0]] <= push_hist;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_valid    <= 1'b0;
            upd_ip       <= '0;
            upd_takb     <= 1'b0;
            upd_hist     <= '0;
            mispredict   <= 1'b0;
            hist_restore <= '0;
            underflow    <= 1'b0;
        end else begin
            upd_valid  <= pop;
            mispredict <= mis;
            if (pop) begin
                upd_ip   <= ip_mem[head_idx];
                upd_takb <= res_takb;
                upd_hist <= hs_mem[head_idx];
            end
            if (mis) hist_restore <= {hs_mem[head_idx][HISTW-2:0], res_takb};
            if (res_valid && empty) underflow <= 1'b1;
        end
    end

`ifdef THOR2022_BUQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd_valid && stat_branches != 32'hFFFFFFFF)     stat_branches    <= stat_branches + 32'd1;
            if (mispredict && stat_mispredicts != 32'hFFFFFFFF) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule
